// File: rtl/fgpio_pattern_sched.sv
// Timed FGPIO command scheduler: a small FIFO of delayed commands replayed cycle-exactly onto the
// shared FGPIO port, with live core requests passed through whenever no pattern command is issuing.
// Build option FGPIO_SCHED_LOOP_EN: stored pattern replays cyclically instead of being consumed.
module fgpio_pattern_sched #(
  parameter int CMD_DEPTH = 4,
  parameter int DLY_W     = 16,
  parameter int CNT_W     = 16
) (
  input  logic             clk_neg_i,
  input  logic             rst_ni,
  input  logic             core_req_i,
  input  logic [6:0]       core_funct7_i,
  input  logic [31:0]      core_rs1_i,
  input  logic [31:0]      core_rs2_i,
  output logic             core_ack_o,
  output logic             core_error_o,
  output logic [31:0]      core_rd_o,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [6:0]       cmd_funct7_i,
  input  logic [31:0]      cmd_rs1_i,
  input  logic [31:0]      cmd_rs2_i,
  input  logic [DLY_W-1:0] cmd_delay_i,
  input  logic             run_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [CNT_W-1:0] issue_cnt_o,
  output logic             fgpio_req_o,
  output logic [6:0]       fgpio_funct7_o,
  output logic [31:0]      fgpio_rs1_o,
  output logic [31:0]      fgpio_rs2_o,
  input  logic             fgpio_ack_i,
  input  logic             fgpio_error_i,
  input  logic [31:0]      fgpio_rd_i
);
  localparam int PTR_W = $clog2(CMD_DEPTH);
  localparam int OCC_W = PTR_W + 1;
`ifdef FGPIO_SCHED_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_ISSUE} state_e;
  typedef struct packed {
    logic [6:0]       funct7;
    logic [31:0]      rs1;
    logic [31:0]      rs2;
    logic [DLY_W-1:0] delay;
  } cmd_t;

  state_e           r_state, w_state_nxt;
  cmd_t             r_mem [CMD_DEPTH];
  cmd_t             r_cur;
  logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr, w_rd_ptr_nxt;
  logic [OCC_W-1:0] r_count, w_count_nxt;
  logic [DLY_W-1:0] r_cnt;
  logic             r_err;
  logic [CNT_W-1:0] r_issue_cnt;
  logic             w_full, w_empty, w_issue, w_push, w_pop, w_last;

  assign w_full       = (r_count == OCC_W'(CMD_DEPTH));
  assign w_empty      = (r_count == '0);
  assign w_issue      = (r_state == S_ISSUE);
  // In loop mode the stored pattern is frozen while it plays.
  assign cmd_ready_o  = !w_full && !flush_i && !(LOOP_EN && (r_state != S_IDLE));
  assign w_push       = cmd_valid_i && cmd_ready_o;
  assign w_pop        = w_issue && !LOOP_EN;
  assign w_last       = (OCC_W'(r_rd_ptr) == (r_count - OCC_W'(1)));
  assign w_rd_ptr_nxt = (LOOP_EN && w_last) ? '0 : r_rd_ptr + PTR_W'(1);
  assign w_count_nxt  = r_count + OCC_W'(w_push) - OCC_W'(w_pop);

  assign busy_o      = (r_state != S_IDLE);
  assign err_o       = r_err;
  assign issue_cnt_o = r_issue_cnt;

  // The pattern owns FGPIO only during ISSUE; its read data is discarded.
  assign fgpio_req_o    = w_issue ? 1'b1         : core_req_i;
  assign fgpio_funct7_o = w_issue ? r_cur.funct7 : core_funct7_i;
  assign fgpio_rs1_o    = w_issue ? r_cur.rs1    : core_rs1_i;
  assign fgpio_rs2_o    = w_issue ? r_cur.rs2    : core_rs2_i;
  assign core_ack_o     = w_issue ? 1'b0         : fgpio_ack_i;
  assign core_error_o   = w_issue ? 1'b0         : fgpio_error_i;
  assign core_rd_o      = w_issue ? '0           : fgpio_rd_i;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    done_o      = 1'b0;
    case (r_state)
      S_IDLE:  if (run_i && !w_empty && !r_err) w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (!run_i)              w_state_nxt = S_IDLE;
        else if (r_cnt == '0)    w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (fgpio_error_i) begin
          w_state_nxt = S_IDLE;
        end else if (w_count_nxt == '0) begin
          done_o      = !LOOP_EN;
          w_state_nxt = S_IDLE;
        end else if (run_i) begin
          w_state_nxt = S_LOAD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush_i) w_state_nxt = S_IDLE;
  end

  // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
  always_ff @(posedge clk_neg_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_issue_cnt <= '0;
      r_cur       <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_issue) r_issue_cnt <= r_issue_cnt + CNT_W'(1);
      if (flush_i) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
        r_err    <= 1'b0;
      end else begin
        if (w_push)                  r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_issue)                 r_rd_ptr <= w_rd_ptr_nxt;
        if (w_issue && fgpio_error_i) r_err   <= 1'b1;
        r_count <= w_count_nxt;
      end
      if (r_state == S_LOAD) begin
        r_cur <= r_mem[r_rd_ptr];
        r_cnt <= r_mem[r_rd_ptr].delay;
      end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - DLY_W'(1);
      end
    end
  end

  // NOTE: storage is deliberately unreset; occupancy and pointers alone define which entries are live.
  always_ff @(posedge clk_neg_i) begin
    if (w_push) r_mem[r_wr_ptr] <= {cmd_funct7_i, cmd_rs1_i, cmd_rs2_i, cmd_delay_i};
  end
endmodule

// File: tb/tb_fgpio_pattern_sched.sv
// Self-checking bench for fgpio_pattern_sched: vector table, directed timing sequences and a
// randomized run against a queue-based reference model of the scheduling rules.
module tb_fgpio_pattern_sched;
  localparam int DEPTH = 4;

  logic        clk_neg_i = 1'b0;
  logic        rst_ni;
  logic        core_req_i, core_ack_o, core_error_o;
  logic [6:0]  core_funct7_i;
  logic [31:0] core_rs1_i, core_rs2_i, core_rd_o;
  logic        cmd_valid_i, cmd_ready_o;
  logic [6:0]  cmd_funct7_i;
  logic [31:0] cmd_rs1_i, cmd_rs2_i;
  logic [15:0] cmd_delay_i;
  logic        run_i, flush_i, busy_o, done_o, err_o;
  logic [15:0] issue_cnt_o;
  logic        fgpio_req_o, fgpio_ack_i, fgpio_error_i;
  logic [6:0]  fgpio_funct7_o;
  logic [31:0] fgpio_rs1_o, fgpio_rs2_o, fgpio_rd_i;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clk_neg_i = ~clk_neg_i;

  fgpio_pattern_sched #(.CMD_DEPTH(DEPTH), .DLY_W(16), .CNT_W(16)) dut (
    .clk_neg_i(clk_neg_i), .rst_ni(rst_ni),
    .core_req_i(core_req_i), .core_funct7_i(core_funct7_i), .core_rs1_i(core_rs1_i),
    .core_rs2_i(core_rs2_i), .core_ack_o(core_ack_o), .core_error_o(core_error_o),
    .core_rd_o(core_rd_o), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_funct7_i(cmd_funct7_i), .cmd_rs1_i(cmd_rs1_i), .cmd_rs2_i(cmd_rs2_i),
    .cmd_delay_i(cmd_delay_i), .run_i(run_i), .flush_i(flush_i), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o), .issue_cnt_o(issue_cnt_o), .fgpio_req_o(fgpio_req_o),
    .fgpio_funct7_o(fgpio_funct7_o), .fgpio_rs1_o(fgpio_rs1_o), .fgpio_rs2_o(fgpio_rs2_o),
    .fgpio_ack_i(fgpio_ack_i), .fgpio_error_i(fgpio_error_i), .fgpio_rd_i(fgpio_rd_i)
  );

  typedef struct packed {
    logic        req;
    logic [6:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic        ack;
    logic        cerr;
    logic [31:0] rd;
    logic        ready;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] cnt;
  } obs_t;

  typedef struct {
    logic        creq;
    logic [6:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic        ack;
    logic        ferr;
    logic [31:0] rd;
    logic        flush;
    obs_t        exp;
  } vec_t;

  typedef struct {
    logic [6:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    int          d;
  } mcmd_t;

  int          q_load[$], q_req[$], q_done[$];
  logic [31:0] q_rs1[$];

  function automatic obs_t sample();
    return '{fgpio_req_o, fgpio_funct7_o, fgpio_rs1_o, fgpio_rs2_o, core_ack_o, core_error_o,
             core_rd_o, cmd_ready_o, busy_o, done_o, err_o, issue_cnt_o};
  endfunction

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1000;
  endfunction

  function automatic logic [31:0] qget32(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hFFFF_FFFF;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_neg_i);
    #1;
    cyc++;
  endtask

  task automatic drive_idle();
    core_req_i = 0; core_funct7_i = '0; core_rs1_i = '0; core_rs2_i = '0;
    cmd_valid_i = 0; cmd_funct7_i = '0; cmd_rs1_i = '0; cmd_rs2_i = '0; cmd_delay_i = '0;
    run_i = 0; flush_i = 0; fgpio_ack_i = 0; fgpio_error_i = 0; fgpio_rd_i = '0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_neg_i);
    #1;
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic push(input logic [6:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [15:0] d);
    cmd_valid_i = 1; cmd_funct7_i = f; cmd_rs1_i = a; cmd_rs2_i = b; cmd_delay_i = d;
    tick();
    cmd_valid_i = 0;
  endtask

  // Runs n cycles, logging rising busy edges, pattern/core request cycles and done pulses.
  task automatic watch(input int n);
    logic pb;
    q_load.delete(); q_req.delete(); q_done.delete(); q_rs1.delete();
    pb = busy_o;
    for (int i = 0; i < n; i++) begin
      tick();
      if (busy_o && !pb) q_load.push_back(cyc);
      if (fgpio_req_o) begin
        q_req.push_back(cyc);
        q_rs1.push_back(fgpio_rs1_o);
      end
      if (done_o) q_done.push_back(cyc);
      pb = busy_o;
    end
  endtask

  vec_t  vt[4];
  mcmd_t mq[$];

  initial begin
    vt[0] = '{1'b0, 7'h00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0,
              '{1'b0, 7'h00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0}};
    vt[1] = '{1'b1, 7'h40, 32'hDEADBEEF, 32'h1, 1'b1, 1'b0, 32'hCAFE0001, 1'b0,
              '{1'b1, 7'h40, 32'hDEADBEEF, 32'h1, 1'b1, 1'b0, 32'hCAFE0001, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0}};
    vt[2] = '{1'b1, 7'h20, 32'h12, 32'h34, 1'b1, 1'b1, 32'h55, 1'b1,
              '{1'b1, 7'h20, 32'h12, 32'h34, 1'b1, 1'b1, 32'h55, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0}};
    vt[3] = '{1'b0, 7'h7F, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0, 1'b0,
              '{1'b0, 7'h7F, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0}};

    do_reset();
    check("reset_state", 128'(sample()), 128'(vt[0].exp));

`ifdef FGPIO_SCHED_LOOP_EN
    push(7'h40, 32'hA, 32'h1, 16'd1);
    push(7'h40, 32'hB, 32'h2, 16'd1);
    run_i = 1;
    watch(20);
    check("loop_issues", 128'(q_req.size()), 128'(5));
    for (int i = 1; i < 4; i++) check("loop_period", 128'(qget(q_req, i) - qget(q_req, i - 1)), 128'(4));
    for (int i = 0; i < 5; i++) check("loop_order", 128'(qget32(q_rs1, i)), 128'((i % 2 == 0) ? 32'hA : 32'hB));
    check("loop_no_done", 128'(q_done.size()), 128'(0));
    check("loop_ready", 128'(cmd_ready_o), 128'(0));
    check("loop_busy", 128'(busy_o), 128'(1));
    check("loop_cnt", 128'(issue_cnt_o), 128'(5));
`else
    // Combinational passthrough vectors while idle.
    for (int i = 0; i < 4; i++) begin
      core_req_i = vt[i].creq; core_funct7_i = vt[i].f; core_rs1_i = vt[i].a; core_rs2_i = vt[i].b;
      fgpio_ack_i = vt[i].ack; fgpio_error_i = vt[i].ferr; fgpio_rd_i = vt[i].rd; flush_i = vt[i].flush;
      #1;
      check($sformatf("table_%0d", i), 128'(sample()), 128'(vt[i].exp));
    end
    drive_idle();
    tick();

    // Single command, zero delay.
    push(7'b1000000, 32'h5, 32'hF, 16'd0);
    run_i = 1;
    watch(6);
    check("single_latency", 128'(qget(q_req, 0) - qget(q_load, 0)), 128'(2));
    check("single_rs1", 128'(qget32(q_rs1, 0)), 128'(32'h5));
    check("single_done", 128'(qget(q_done, 0)), 128'(qget(q_req, 0)));
    check("single_cnt", 128'(issue_cnt_o), 128'(1));
    run_i = 0;

    // Three commands with delay 4: period 7, one done after the third.
    for (int i = 0; i < 3; i++) push(7'b1000000, 32'(i + 1), 32'h0, 16'd4);
    run_i = 1;
    watch(40);
    check("three_issues", 128'(q_req.size()), 128'(3));
    check("three_first", 128'(qget(q_req, 0) - qget(q_load, 0)), 128'(6));
    check("three_gap1", 128'(qget(q_req, 1) - qget(q_req, 0)), 128'(7));
    check("three_gap2", 128'(qget(q_req, 2) - qget(q_req, 1)), 128'(7));
    check("three_done_n", 128'(q_done.size()), 128'(1));
    check("three_done_at", 128'(qget(q_done, 0)), 128'(qget(q_req, 2)));
    check("three_empty", 128'({busy_o, cmd_ready_o, issue_cnt_o}), 128'({1'b0, 1'b1, 16'd4}));
    run_i = 0;

    // Core request held across a pattern issue.
    push(7'h40, 32'h1234, 32'h55, 16'd0);
    core_req_i = 1; core_funct7_i = 7'h11; core_rs1_i = 32'hAAAA; core_rs2_i = 32'hBBBB;
    fgpio_ack_i = 1; fgpio_rd_i = 32'hC0DE;
    run_i = 1;
    tick();
    tick();
    tick();
    check("arb_issue", 128'({fgpio_req_o, core_ack_o, fgpio_funct7_o, fgpio_rs1_o, fgpio_rs2_o, core_rd_o}),
          128'({1'b1, 1'b0, 7'h40, 32'h1234, 32'h55, 32'h0}));
    tick();
    check("arb_after", 128'({core_ack_o, fgpio_funct7_o, fgpio_rs1_o, fgpio_rs2_o, core_rd_o, issue_cnt_o}),
          128'({1'b1, 7'h11, 32'hAAAA, 32'hBBBB, 32'hC0DE, 16'd5}));
    drive_idle();

    // Illegal pattern command: sticky error blocks further loads until flush.
    push(7'b0100000, 32'h1, 32'h0, 16'd0);
    push(7'b1000000, 32'h2, 32'h0, 16'd0);
    fgpio_error_i = 1;
    run_i = 1;
    tick();
    tick();
    tick();
    check("err_issue", 128'({fgpio_req_o, fgpio_funct7_o}), 128'({1'b1, 7'b0100000}));
    tick();
    check("err_set", 128'({err_o, busy_o, issue_cnt_o}), 128'({1'b1, 1'b0, 16'd6}));
    watch(8);
    check("err_blocks", 128'(q_load.size()), 128'(0));
    fgpio_error_i = 0;
    flush_i = 1;
    #1;
    check("flush_ready", 128'(cmd_ready_o), 128'(0));
    tick();
    flush_i = 0;
    watch(4);
    check("flush_clear", 128'({err_o, busy_o, cmd_ready_o}), 128'({1'b0, 1'b0, 1'b1}));
    check("flush_empty", 128'(q_load.size()), 128'(0));
    run_i = 0;

    // run_i dropped mid-wait, then the full delay replays.
    push(7'h40, 32'h66, 32'h0, 16'd10);
    run_i = 1;
    tick();
    repeat (5) tick();
    run_i = 0;
    watch(3);
    check("drop_idle", 128'({busy_o, 8'(q_req.size())}), 128'({1'b0, 8'd0}));
    run_i = 1;
    watch(20);
    check("drop_replay", 128'(qget(q_req, 0) - qget(q_load, 0)), 128'(12));
    check("drop_rs1", 128'(qget32(q_rs1, 0)), 128'(32'h66));
    run_i = 0;

    // Full FIFO, then a flush coinciding with an issue.
    for (int i = 0; i < DEPTH; i++) push(7'h40, 32'(i), 32'h0, 16'd0);
    check("full_ready", 128'(cmd_ready_o), 128'(0));
    run_i = 1;
    tick();
    tick();
    tick();
    flush_i = 1;
    #1;
    check("flush_issue_req", 128'({fgpio_req_o, cmd_ready_o}), 128'({1'b1, 1'b0}));
    tick();
    flush_i = 0;
    check("flush_issue_cnt", 128'({issue_cnt_o, busy_o}), 128'({16'd8, 1'b0}));
    watch(4);
    check("flush_issue_empty", 128'(q_load.size()), 128'(0));

    // Randomized run against the reference model.
    do_reset();
    begin
      bit          m_act, m_err, in_issue, ready, push_c;
      int          m_age, after;
      logic [15:0] m_cnt;
      mcmd_t       hd;
      obs_t        e;
      m_act = 0; m_err = 0; m_age = 0; m_cnt = '0;
      mq.delete();
      for (int i = 0; i < 600; i++) begin
        run_i = ($urandom_range(0, 9) < 8);
        flush_i = ($urandom_range(0, 39) == 0);
        cmd_valid_i = 1'($urandom_range(0, 1));
        cmd_funct7_i = 7'($urandom); cmd_rs1_i = $urandom; cmd_rs2_i = $urandom;
        cmd_delay_i = 16'($urandom_range(0, 4));
        core_req_i = 1'($urandom_range(0, 1)); core_funct7_i = 7'($urandom);
        core_rs1_i = $urandom; core_rs2_i = $urandom;
        fgpio_ack_i = 1'($urandom_range(0, 1)); fgpio_error_i = ($urandom_range(0, 11) == 0);
        fgpio_rd_i = $urandom;
        #1;
        in_issue = m_act && (mq.size() > 0) && (m_age == mq[0].d + 2);
        hd = in_issue ? mq[0] : '{7'h0, 32'h0, 32'h0, 0};
        ready = (mq.size() < DEPTH) && !flush_i;
        push_c = cmd_valid_i && ready;
        after = mq.size() - (in_issue ? 1 : 0) + (push_c ? 1 : 0);
        e.req = in_issue ? 1'b1 : core_req_i;
        e.f = in_issue ? hd.f : core_funct7_i;
        e.a = in_issue ? hd.a : core_rs1_i;
        e.b = in_issue ? hd.b : core_rs2_i;
        e.ack = in_issue ? 1'b0 : fgpio_ack_i;
        e.cerr = in_issue ? 1'b0 : fgpio_error_i;
        e.rd = in_issue ? 32'h0 : fgpio_rd_i;
        e.ready = ready; e.busy = m_act; e.err = m_err; e.cnt = m_cnt;
        e.done = in_issue && !fgpio_error_i && (after == 0);
        check("random", 128'(sample()), 128'(e));
        if (in_issue) begin
          m_cnt++;
          void'(mq.pop_front());
          if (fgpio_error_i) begin m_err = 1; m_act = 0; end
          else if (after == 0) m_act = 0;
          else if (run_i) m_age = 0;
          else m_act = 0;
        end else if (m_act) begin
          if (m_age == 0) m_age = 1;
          else if (!run_i) m_act = 0;
          else m_age++;
        end else if (run_i && (mq.size() > 0) && !m_err) begin
          m_act = 1; m_age = 0;
        end
        if (push_c) mq.push_back('{cmd_funct7_i, cmd_rs1_i, cmd_rs2_i, int'(cmd_delay_i)});
        if (flush_i) begin mq.delete(); m_act = 0; m_err = 0; end
        tick();
      end
    end
`endif
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
